// File: rtl/tdc_thermo_decoder.sv
// Receiving end of a CARRY4 tapped delay line: detects a hit edge at tap 0 and
// emits a {coarse, fine} timestamp with a bubble-tolerant population-count fine value.
module tdc_thermo_decoder #(
  parameter int NCARRY4  = 8,
  parameter int COARSE_W = 16,
  parameter int FINE_W   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*NCARRY4-1:0]  taps_in,
  output logic                  ts_valid,
  input  logic                  ts_ready,
  output logic [COARSE_W-1:0]   ts_coarse,
  output logic [FINE_W-1:0]     ts_fine,
  output logic                  overflow
);

  localparam int TAPS = 4 * NCARRY4;

  logic [TAPS-1:0]               s1_q, s2_q;
  logic                          s2_prev0_q;
  logic [COARSE_W-1:0]           coarse_q, coarse_d;
  logic                          hit;

  logic                          p1_valid_q;
  logic [NCARRY4-1:0][2:0]       p1_nib_q, p1_nib_d;
  logic [COARSE_W-1:0]           p1_coarse_q;

  logic                          p2_valid_q;
  logic [FINE_W-1:0]             p2_fine_q, p2_fine_d;
  logic [COARSE_W-1:0]           p2_coarse_q;

  logic                          ts_valid_q, ts_valid_d;
  logic [COARSE_W-1:0]           ts_coarse_q, ts_coarse_d;
  logic [FINE_W-1:0]             ts_fine_q, ts_fine_d;
  logic                          overflow_q, overflow_d;
  logic                          load, drop;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Only the second sample stage is trusted; s1 may be metastable.
  assign hit      = en & s2_q[0] & ~s2_prev0_q;
  assign coarse_d = en ? coarse_q + COARSE_W'(1) : '0;

  always_comb begin
    p1_nib_d = '0;
    for (int i = 0; i < NCARRY4; i++) begin
      p1_nib_d[i] = popcnt4(s2_q[4*i +: 4]);
    end
  end

  always_comb begin
    p2_fine_d = '0;
    for (int i = 0; i < NCARRY4; i++) begin
      p2_fine_d = p2_fine_d + FINE_W'(p1_nib_q[i]);
    end
  end

  // A result arriving while the held word is stalled is dropped, not queued.
  always_comb begin
    load        = en & p2_valid_q & (~ts_valid_q | ts_ready);
    drop        = en & p2_valid_q & ts_valid_q & ~ts_ready;
    ts_valid_d  = ts_valid_q;
    ts_coarse_d = ts_coarse_q;
    ts_fine_d   = ts_fine_q;
    if (load) begin
      ts_valid_d  = 1'b1;
      ts_coarse_d = p2_coarse_q;
      ts_fine_d   = p2_fine_q;
    end else if (ts_ready) begin
      ts_valid_d  = 1'b0;
    end
    overflow_d = en ? (overflow_q | drop) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s2_prev0_q  <= 1'b0;
      coarse_q    <= '0;
      p1_valid_q  <= 1'b0;
      p1_nib_q    <= '0;
      p1_coarse_q <= '0;
      p2_valid_q  <= 1'b0;
      p2_fine_q   <= '0;
      p2_coarse_q <= '0;
      ts_valid_q  <= 1'b0;
      ts_coarse_q <= '0;
      ts_fine_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      s1_q        <= taps_in;
      s2_q        <= s1_q;
      s2_prev0_q  <= s2_q[0];
      coarse_q    <= coarse_d;
      p1_valid_q  <= hit;
      p1_nib_q    <= p1_nib_d;
      p1_coarse_q <= coarse_q;
      p2_valid_q  <= en & p1_valid_q;
      p2_fine_q   <= p2_fine_d;
      p2_coarse_q <= p1_coarse_q;
      ts_valid_q  <= ts_valid_d;
      ts_coarse_q <= ts_coarse_d;
      ts_fine_q   <= ts_fine_d;
      overflow_q  <= overflow_d;
    end
  end

  assign ts_valid  = ts_valid_q;
  assign ts_coarse = ts_coarse_q;
  assign ts_fine   = ts_fine_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/tdc_thermo_decoder.md
Name: tdc_thermo_decoder

Overview:
- Receiving end of the CARRY4 tapped delay line.
- Samples the raw carry-out tap bus every clock and detects the arrival of a hit edge at tap 0.
- Converts the thermometer code into a bubble-tolerant fine count, pairs it with a free-running coarse counter, and presents {coarse, fine} timestamps on a valid/ready stream to the downstream TDC event logic.

Parameters:
- NCARRY4, 8, number of chained CARRY4 cells; TAPS = 4*NCARRY4 (32 by default).
- COARSE_W, 16, coarse counter width.
- FINE_W, 6, fine count width; must satisfy 2^FINE_W > TAPS.

Ports:
- clk  input  1  system clock; also the sampling clock of the delay line.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  measurement enable.
- taps_in  input  TAPS  raw CO bus from the delay line; asynchronous to clk.
- ts_valid  output  1  timestamp available.
- ts_ready  input  1  downstream accepts timestamp.
- ts_coarse  output  COARSE_W  coarse count latched at hit detection.
- ts_fine  output  FINE_W  ones-count of sampled taps at hit detection.
- overflow  output  1  sticky: a hit was dropped.

Behaviour:
Reset (rst_n low, asynchronous):
- All registers clear: sample stages, previous-sample bit, pipeline, coarse counter.
- ts_valid=0, ts_coarse=0, ts_fine=0, overflow=0.

Sampling:
- s1 <= taps_in; s2 <= s1 (two-flop capture).
- s2_prev0 <= s2[0].
- Delay-line bits are never used before s2.

Hit detect:
- hit = en & s2[0] & ~s2_prev0.
- This is a rising edge at the first tap between consecutive cycles.
- A level held high produces exactly one hit.

Coarse counter:
- Increments by 1 every cycle while en=1 and wraps 2^COARSE_W-1 -> 0.
- Held at 0 while en=0.
- The value sampled in the hit cycle is carried with the event.

Fine decode (bubble tolerant):
- fine = population count of s2 over all TAPS bits.
- No first-zero search.
- Range 1..TAPS on a hit; fine=TAPS when all taps are 1.
- Pipelined in 2 stages:
  - P1: per-CARRY4 nibble counts (0..4), registered with the hit flag and coarse value.
  - P2: sum of the nibble counts, registered.

Latency:
- Hit detected in cycle H -> ts_valid rises at the clock edge ending cycle H+2.
- The pipeline accepts a new hit every cycle.

Output handshake:
- Transfer occurs when ts_valid & ts_ready at a clock edge.
- ts_coarse and ts_fine are stable while ts_valid=1 and not accepted.
- ts_valid drops after a transfer unless a new P2 result loads in the same edge; in that case it stays 1 with the new data.
- If P2 has a result while ts_valid=1 and ts_ready=0:
  - The result is discarded and overflow sets.
  - The held output is unchanged.

overflow:
- Sticky; cleared only by reset or by en low for at least one cycle.

en low:
- Blocks new hits and flushes the P1/P2 valid flags.
- Does not clear a pending ts_valid; that word still completes its handshake.

Simultaneous events:
- A transfer and an arriving P2 result on the same edge -> the new result loads with no overflow.
- Reset mid-pipeline -> in-flight events are lost and no ts_valid follows.

Test Plan:
- Reset: assert rst_n=0 mid-run with ts_valid=1 -> all outputs 0 immediately (asynchronously); no event emitted for 5 cycles after release with taps_in=0.
- Basic decode: en=1, taps_in 0 -> 0x000000FF in cycle H (detected after 2 sample stages) -> exactly one ts_valid with ts_fine=8 and ts_coarse equal to the counter value in the hit cycle, 2 cycles after detection; holding 0xFF produces no second event.
- Bubble: taps_in 0 -> 0x000007DF (bubble at bit 5) -> ts_fine=10; all-ones 0xFFFFFFFF -> ts_fine=32.
- Backpressure: ts_ready=0, two hits 4 cycles apart (0x0F then 0x3F) -> first word (fine=4) held stable and overflow=1 after the second; raise ts_ready -> single transfer, overflow stays 1 until en pulsed low.
- Back-to-back: alternate taps_in 0 / 0x1 with ts_ready=1 -> one event every 2 cycles, all fine=1, coarse values differing by 2, overflow=0.
- Wrap and enable: COARSE_W=4, hits after 15 and 17 cycles of en -> coarse 15 then 1; en low -> counter reads 0 on next hit after re-enable.
